// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative shift-add multiplier.
package mul_pkg;

  localparam int unsigned DefaultXlen = 32;
  localparam int unsigned CntW        = $clog2(DefaultXlen);

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

endpackage

// File: rtl/mul_opnd_abs.sv
// Conditional two's-complement magnitude of one operand, plus its sign flag.
module mul_opnd_abs #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         sign_i,
  output logic [W-1:0] mag_o,
  output logic         neg_o
);

  // The most negative value maps onto 2^(W-1), which still fits as unsigned.
  assign neg_o = sign_i & val_i[W-1];
  assign mag_o = neg_o ? (~val_i + 1'b1) : val_i;

endmodule

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier, one multiplier bit per cycle on magnitudes.
// Define MUL_EARLY_OUT_EN to leave CALC once the remaining multiplier bits are zero.
module mul_iter
  import mul_pkg::*;
#(
  parameter int unsigned XLEN = DefaultXlen
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              sign,
  input  logic [XLEN-1:0]   src1,
  input  logic [XLEN-1:0]   src2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*XLEN-1:0] result,
  output logic              busy
);

  localparam int unsigned CntBits = (XLEN > 1) ? $clog2(XLEN) : 1;

  state_e              state_q;
  logic [2*XLEN-1:0]   mcand_q;
  logic [XLEN-1:0]     mplier_q;
  logic [2*XLEN-1:0]   prod_q, prod_d;
  logic [CntBits-1:0]  cnt_q;
  logic                neg_q;
  logic [2*XLEN-1:0]   result_q;
  logic                last_step;

  logic [XLEN-1:0]     mag1, mag2;
  logic                neg1, neg2;

  mul_opnd_abs #(.W(XLEN)) u_abs1 (
    .val_i  (src1),
    .sign_i (sign),
    .mag_o  (mag1),
    .neg_o  (neg1)
  );

  mul_opnd_abs #(.W(XLEN)) u_abs2 (
    .val_i  (src2),
    .sign_i (sign),
    .mag_o  (mag2),
    .neg_o  (neg2)
  );

  always_comb begin
    prod_d    = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
    last_step = (cnt_q == CntBits'(XLEN - 1));
`ifdef MUL_EARLY_OUT_EN
    last_step = last_step || ((mplier_q >> 1) == '0);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else if (flush) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            mcand_q  <= {{XLEN{1'b0}}, mag1};
            mplier_q <= mag2;
            neg_q    <= neg1 ^ neg2;
            prod_q   <= '0;
            cnt_q    <= '0;
            state_q  <= StCalc;
          end
        end
        StCalc: begin
          prod_q   <= prod_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (last_step) begin
            state_q  <= StDone;
            result_q <= neg_q ? (~prod_d + 1'b1) : prod_d;
          end
        end
        StDone: begin
          if (out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign result    = result_q;

endmodule

// File: tb/tb_mul_iter.sv
// Self-checking bench for mul_iter: directed corner cases plus random operations.
module tb_mul_iter;

  localparam int unsigned XLEN = 32;

  logic              clk = 1'b0;
  logic              reset, flush, in_valid, in_ready, sign;
  logic [XLEN-1:0]   src1, src2;
  logic              out_valid, out_ready, busy;
  logic [2*XLEN-1:0] result;

  int checks = 0;
  int errors = 0;

  mul_iter #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign      (sign),
    .src1      (src1),
    .src2      (src2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Exact product computed with wide host arithmetic.
  function automatic logic [63:0] ref_prod(input logic s, input logic [31:0] a,
                                           input logic [31:0] b);
    longint sa, sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  // Number of CALC cycles the operation should take.
  function automatic int calc_len(input logic s, input logic [31:0] b);
`ifdef MUL_EARLY_OUT_EN
    longint unsigned m;
    int p;
    m = (s && b[31]) ? (64'h1_0000_0000 - {32'b0, b}) : {32'b0, b};
    if (m == 0) return 1;
    p = 0;
    for (int i = 0; i < 33; i++) if (m[i]) p = i;
    return p + 1;
`else
    if (s || b != 0) return XLEN;
    return XLEN;
`endif
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Runs one operation from IDLE; called and returns on a negedge.
  task automatic run_op(input string tag, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    logic [63:0] exp;
    int k;
    bit ok;
    exp = ref_prod(s, a, b);
    chk({tag, " in_ready before"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; sign = s; src1 = a; src2 = b; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; sign = ~s; src1 = $urandom; src2 = $urandom;
    k = 0;
    while (!out_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    // out_valid is seen by the consumer at edge T+k+1.
    chk({tag, " latency"}, 64'(k + 1), 64'(calc_len(s, b) + 1));
    chk({tag, " result"}, result, exp);
    if (!out_valid) begin
      do_reset();
      return;
    end
    ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (result !== exp || out_valid !== 1'b1 || in_ready !== 1'b0) ok = 1'b0;
    end
    if (hold > 0) chk({tag, " hold stable"}, 64'(ok), 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " back to idle"}, {62'd0, in_ready, out_valid}, 64'b10);
  endtask

  initial begin
    bit ok;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; sign = 1'b0;
    src1 = '0; src2 = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset state", {59'd0, in_ready, out_valid, busy, 2'b00}, {59'd0, 3'b100, 2'b00});
    chk("reset result", result, 64'd0);

    run_op("umax", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    chk("umax literal", ref_prod(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
    run_op("s-7x3", 1'b1, 32'hFFFF_FFF9, 32'd3, 10);
    run_op("sminxmin", 1'b1, 32'h8000_0000, 32'h8000_0000, 2);
    run_op("s-1x-1", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("u-1x-1", 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1);

    // Flush in the 5th CALC cycle of 123x456.
    in_valid = 1'b1; sign = 1'b0; src1 = 32'd123; src2 = 32'd456;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre-flush busy", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush idle", {61'd0, in_ready, out_valid, busy}, 64'b100);
    ok = 1'b1;
    for (int i = 0; i < XLEN + 4; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) ok = 1'b0;
    end
    chk("flush no out_valid", 64'(ok), 64'd1);
    run_op("2x3", 1'b0, 32'd2, 32'd3, 0);

    // A request presented together with flush is not accepted.
    in_valid = 1'b1; flush = 1'b1; src1 = 32'd9; src2 = 32'd9;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    chk("flush blocks accept", {62'd0, busy, in_ready}, 64'b01);

    // Reset in the middle of CALC.
    in_valid = 1'b1; sign = 1'b1; src1 = 32'hDEAD_BEEF; src2 = 32'h1234_5678;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid reset flags", {61'd0, in_ready, out_valid, busy}, 64'b100);
    chk("mid reset result", result, 64'd0);
    run_op("after reset", 1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 0);

    run_op("5x0", 1'b0, 32'd5, 32'd0, 0);
    run_op("5x0x10", 1'b0, 32'd5, 32'h10, 0);
    run_op("s5x-16", 1'b1, 32'd5, 32'hFFFF_FFF0, 0);

    for (int n = 0; n < 16; n++) begin
      logic s;
      logic [31:0] a, b;
      s = 1'($urandom);
      a = $urandom;
      b = (n % 4 == 0) ? ($urandom & 32'h0000_00FF) : $urandom;
      run_op($sformatf("rand%0d", n), s, a, b, int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_iter.md
# mul_iter

Iterative shift-add multiplier for the EXE stage, the multiply-side counterpart to the sequential divider. It accepts one signed or unsigned XLEN×XLEN operation through a valid/ready request handshake and iterates one multiplier bit per cycle on magnitudes. It returns the full 2·XLEN product through a valid/ready response handshake. The pipeline selects the high or low half (mulh/mul) and drives `flush` on exception or branch cancel.

## Interface
- `XLEN`, default 32: operand width; product is 2·XLEN.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `flush`  in  1  abandon any in-flight or pending operation.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  block idle and able to accept.
- `sign`  in  1  1 = signed (two's complement), 0 = unsigned.
- `src1`  in  XLEN  multiplicand.
- `src2`  in  XLEN  multiplier.
- `out_valid`  out  1  `result` valid.
- `out_ready`  in  1  consumer accepts `result`.
- `result`  out  2·XLEN  product, {hi, lo}.
- `busy`  out  1  state ≠ IDLE.

## Operation
- States: IDLE, CALC, DONE.
- IDLE: `in_ready`=1. On `in_valid`:
  - latch mcand = zero-extended |src1| into 2·XLEN, mplier = |src2|, neg = sign & (src1[XLEN-1] ^ src2[XLEN-1]), prod = 0, cnt = 0;
  - go to CALC.
  - Magnitude is taken only when `sign`=1 and the operand MSB is set. |−2^(XLEN−1)| = 2^(XLEN−1) fits unsigned.
- CALC, each cycle:
  - if mplier[0], prod += mcand (2·XLEN, modulo);
  - mcand <<= 1, mplier >>= 1, cnt++.
  - After the cycle with cnt = XLEN−1, go to DONE. `result` is registered on that edge as neg ? −prod_next : prod_next.
- DONE: `out_valid`=1 and `result` held stable. On `out_ready`, go to IDLE. No new request is accepted in the same cycle; `in_ready` rises the following cycle.
- `flush` (any state): next state IDLE, `out_valid` drops the next cycle, and the result is discarded.
  - `flush` overrides both `in_valid` and `out_ready` in the same cycle.
  - A request presented with `flush` is not accepted.
- `reset` (including mid-operation): state IDLE, `out_valid`=0, `result`=0, cnt=0, `busy`=0, `in_ready`=1 after the reset edge.
- Operands and `sign` are sampled only at acceptance. Later changes have no effect.
- Arithmetic: the product is exact in all cases; no overflow is possible in 2·XLEN.
  - signed (−2^31)·(−2^31) = 0x4000_0000_0000_0000.
  - unsigned 0xFFFF_FFFF² = 0xFFFF_FFFE_0000_0001.

## Timing
- Acceptance edge T (IDLE & `in_valid` & ~`flush`). CALC spans XLEN cycles. `out_valid` is high from edge T+XLEN+1, i.e. 33 cycles after acceptance for XLEN=32.
- `out_valid` stays high until the `out_ready` cycle, regardless of back-pressure duration.
- Throughput: one operation per XLEN+2 cycles minimum, counting the return-to-IDLE cycle.
- Outputs are all registered or derived from state. There is no combinational path from inputs to outputs except none; `in_ready` is a function of state only.

## Configuration
- `MUL_EARLY_OUT_EN` defined: CALC exits to DONE after the cycle whose shifted mplier is zero. CALC length is max(1, p+1), where p is the bit index of the MSB of |src2|. A zero multiplier takes 1 CALC cycle, so `out_valid` rises at T+2. Results are identical to the non-early-out case.
- Undefined: fixed XLEN CALC cycles for every operand. The early-out comparator is not synthesized.

## Structure
- Shared package `mul_pkg`: state enum (IDLE/CALC/DONE), `XLEN` default constant, and the counter width localparam $clog2(XLEN).
- One natural sub-module, `mul_opnd_abs`: combinational conditional two's-complement magnitude plus sign flag. It is instantiated twice, for src1 and src2.
- FSM, shift registers, accumulator and final negation live in `mul_iter`.

## Test plan
- Unsigned 0xFFFF_FFFF × 0xFFFF_FFFF, `out_ready`=1 → `result`=0xFFFF_FFFE_0000_0001, `out_valid` exactly 33 cycles after acceptance.
- Signed −7 × 3 → 0xFFFF_FFFF_FFFF_FFEB. Signed 0x8000_0000 × 0x8000_0000 → 0x4000_0000_0000_0000. Signed −1 × −1 → 1.
- Hold `out_ready`=0 for 10 cycles after `out_valid` → `result` stable and `in_ready`=0 throughout. Then assert `out_ready` → IDLE next cycle.
- `flush` at the 5th CALC cycle of 123×456 → IDLE next cycle, no `out_valid`. The next request 2×3 returns 6.
- `reset` asserted mid-CALC → all outputs at reset values next cycle. A new operation completes correctly.
- With `MUL_EARLY_OUT_EN`: 5×0 → `out_valid` at T+2, `result`=0. 5×0x10 → 5 CALC cycles, `result`=0x50. Without the macro, both take 33 cycles.
